// File: rtl/m68k_dtack_gen.sv
// m68k_dtack_gen: address-class decoder and DTACK generator for a 68k bus.
// Each strobe is classed once as ROM, RAM, IO or unmapped. nDTACK is then
// asserted after that class's programmed number of wait cycles.
// Optional feature: define M68K_BUS_TIMEOUT_EN to acknowledge unmapped
// accesses after TIMEOUT_CYCLES edges and pulse TIMEOUT_ERR when that happens.
// Without the macro, unmapped accesses are never acknowledged.
module m68k_dtack_gen #(
  parameter int unsigned WAIT_ROM       = 0,
  parameter int unsigned WAIT_RAM       = 0,
  parameter int unsigned WAIT_IO        = 1,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        CLK_68KCLK,
  input  logic        RESET,
  input  logic [23:1] M68K_ADDR,
  input  logic        nAS,
  output logic        nDTACK,
  output logic [2:0]  REGION,
  output logic        TIMEOUT_ERR
);

  localparam int unsigned CNT_W = 8;

  localparam logic [2:0] ST_END   = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_ACK   = 3'd3;
  localparam logic [2:0] ST_UNMAP = 3'd4;

  localparam logic [2:0] REG_NONE = 3'b000;
  localparam logic [2:0] REG_ROM  = 3'b001;
  localparam logic [2:0] REG_RAM  = 3'b010;
  localparam logic [2:0] REG_IO   = 3'b100;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       region_nxt;
  logic             ndtack_nxt;
  logic [2:0]       dec_region;
  logic [CNT_W-1:0] dec_wait;
  logic             unused_addr_low;

  // Only the top nibble selects the class; the rest of the address is ignored.
  assign unused_addr_low = ^M68K_ADDR[19:1];

  // Address-class decode of the current bus address.
  always_comb begin
    dec_region = REG_NONE;
    dec_wait   = '0;
    case (M68K_ADDR[23:20])
      4'h0, 4'h2, 4'hC: begin
        dec_region = REG_ROM;
        dec_wait   = CNT_W'(WAIT_ROM);
      end
      4'h1, 4'hD: begin
        dec_region = REG_RAM;
        dec_wait   = CNT_W'(WAIT_RAM);
      end
      4'h3, 4'h4: begin
        dec_region = REG_IO;
        dec_wait   = CNT_W'(WAIT_IO);
      end
      default: begin
        dec_region = REG_NONE;
        dec_wait   = '0;
      end
    endcase
  end

`ifdef M68K_BUS_TIMEOUT_EN
  logic terr_nxt;
`endif

  // Next-state, counter and output values for the bus-cycle FSM.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    region_nxt = REGION;
    ndtack_nxt = nDTACK;
`ifdef M68K_BUS_TIMEOUT_EN
    terr_nxt   = 1'b0;
`endif
    case (state)
      ST_END: begin
        ndtack_nxt = 1'b1;
        region_nxt = REG_NONE;
        if (nAS) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        ndtack_nxt = 1'b1;
        region_nxt = REG_NONE;
        if (!nAS) begin
          region_nxt = dec_region;
          if (dec_region == REG_NONE) begin
            state_nxt = ST_UNMAP;
            cnt_nxt   = CNT_W'(TIMEOUT_CYCLES);
          end else if (dec_wait == '0) begin
            state_nxt  = ST_ACK;
            ndtack_nxt = 1'b0;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = dec_wait;
          end
        end
      end
      ST_WAIT: begin
        ndtack_nxt = 1'b1;
        if (nAS) begin
          // CPU abandoned the cycle before it was acknowledged.
          state_nxt  = ST_IDLE;
          region_nxt = REG_NONE;
        end else if (cnt == CNT_W'(1)) begin
          state_nxt  = ST_ACK;
          ndtack_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_ACK: begin
        ndtack_nxt = 1'b0;
        if (nAS) begin
          state_nxt  = ST_IDLE;
          ndtack_nxt = 1'b1;
          region_nxt = REG_NONE;
        end
      end
      ST_UNMAP: begin
        ndtack_nxt = 1'b1;
        if (nAS) begin
          state_nxt  = ST_IDLE;
          region_nxt = REG_NONE;
        end
`ifdef M68K_BUS_TIMEOUT_EN
        else if (cnt == CNT_W'(1)) begin
          state_nxt  = ST_ACK;
          ndtack_nxt = 1'b0;
          terr_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
`endif
      end
      default: begin
        state_nxt  = ST_END;
        ndtack_nxt = 1'b1;
        region_nxt = REG_NONE;
      end
    endcase
  end

  // State, counter and registered outputs; reset overrides everything.
  always_ff @(posedge CLK_68KCLK) begin
    if (RESET) begin
      state  <= ST_END;
      cnt    <= '0;
      nDTACK <= 1'b1;
      REGION <= REG_NONE;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      nDTACK <= ndtack_nxt;
      REGION <= region_nxt;
    end
  end

`ifdef M68K_BUS_TIMEOUT_EN
  // One-cycle pulse marking an unmapped access acknowledged by timeout.
  always_ff @(posedge CLK_68KCLK) begin
    if (RESET) TIMEOUT_ERR <= 1'b0;
    else       TIMEOUT_ERR <= terr_nxt;
  end
`else
  assign TIMEOUT_ERR = 1'b0;
`endif

endmodule
